pwm_duty_slew: RTL

- Sits between the SPI register bank and the PWM generator.
- Takes the SPI-written duty-cycle register as a target and drives the PWM duty input toward it in bounded steps at a programmable rate, so software writes never cause abrupt duty jumps.
- Provides a bypass mode, a ramping status and a one-cycle arrival pulse.

---
 rtl/pwm_duty_slew.sv | 115 +++++++++++
 1 files changed

// File: rtl/pwm_duty_slew.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_duty_slew
//  Purpose  : Slew-rate limiter between the SPI duty register and the PWM
//             generator. The output duty walks toward the requested target in
//             steps of at most STEP, one step per prescaled tick, so a software
//             write never produces an abrupt duty jump. A bypass mode lets the
//             output follow the target directly.
//  Ports    :
//    clk            in   1      system clock, rising edge
//    rst            in   1      synchronous active-high reset
//    i_target_duty  in   WIDTH  requested duty (sampled every edge)
//    i_step_div     in   8      one step tick every i_step_div+1 clocks
//    i_slew_en      in   1      1 = slew limited, 0 = bypass
//    o_duty_out     out  WIDTH  registered duty to the PWM generator
//    o_ramping      out  1      (duty != target) && slew enabled, combinational
//    o_done         out  1      one-cycle pulse when a ramp step lands on target
//  Revision : 1.0  initial release
// ============================================================================
module pwm_duty_slew #(
  parameter int WIDTH      = 8,
  parameter int STEP       = 1,
  parameter int RESET_DUTY = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_target_duty,
  input  logic [7:0]       i_step_div,
  input  logic             i_slew_en,
  output logic [WIDTH-1:0] o_duty_out,
  output logic             o_ramping,
  output logic             o_done
);

  // Direction encoding, derived fresh every cycle from duty vs. target.
  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_UP   = 2'd1;
  localparam logic [1:0] c_ST_DOWN = 2'd2;

  localparam logic [WIDTH:0]   c_STEP       = (WIDTH+1)'(STEP);
  localparam logic [WIDTH-1:0] c_RESET_DUTY = WIDTH'(RESET_DUTY);

  logic [WIDTH-1:0] r_duty;
  logic [7:0]       r_cnt;
  logic             r_done;

  logic [1:0]       w_state;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_next;
  logic             w_tick;

  always_comb begin
    w_state = c_ST_IDLE;
    if (i_target_duty > r_duty) begin
      w_state = c_ST_UP;
    end else if (i_target_duty < r_duty) begin
      w_state = c_ST_DOWN;
    end
  end

  // Distance to target and the next stepped value. The distance is computed
  // one bit wider so neither direction can wrap; when the remaining distance
  // is within one step we land exactly on target, which also keeps the
  // duty+STEP / duty-STEP arithmetic inside the legal range.
  always_comb begin
    w_diff = '0;
    w_next = r_duty;
    case (w_state)
      c_ST_UP: begin
        w_diff = {1'b0, i_target_duty} - {1'b0, r_duty};
        w_next = (w_diff <= c_STEP) ? i_target_duty : WIDTH'({1'b0, r_duty} + c_STEP);
      end
      c_ST_DOWN: begin
        w_diff = {1'b0, r_duty} - {1'b0, i_target_duty};
        w_next = (w_diff <= c_STEP) ? i_target_duty : WIDTH'({1'b0, r_duty} - c_STEP);
      end
      default: begin
        w_diff = '0;
        w_next = r_duty;
      end
    endcase
  end

  // >= rather than == so that lowering i_step_div below the current count
  // produces a tick on the very next edge instead of waiting for a wrap.
  assign w_tick = i_slew_en && (w_state != c_ST_IDLE) && (r_cnt >= i_step_div);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_duty <= c_RESET_DUTY;
      r_cnt  <= 8'd0;
      r_done <= 1'b0;
    end else if (!i_slew_en) begin
      r_duty <= i_target_duty;
      r_cnt  <= 8'd0;
      r_done <= 1'b0;
    end else if (w_state == c_ST_IDLE) begin
      r_cnt  <= 8'd0;
      r_done <= 1'b0;
    end else if (w_tick) begin
      r_duty <= w_next;
      r_cnt  <= 8'd0;
      r_done <= (w_next == i_target_duty);
    end else begin
      r_cnt  <= r_cnt + 8'd1;
      r_done <= 1'b0;
    end
  end

  assign o_duty_out = r_duty;
  assign o_done     = r_done;
  assign o_ramping  = (r_duty != i_target_duty) && i_slew_en;

endmodule
`default_nettype wire
